dmem_line_responder: RTL and testbench
======================================

DMEM_LINE_RESPONDER -- requirements
Module: dmem_line_responder

Interface
REQ-001 SHALL have parameters: XLEN, default 32, data word width; LINE_BITS, default 16, line-index width; DEPTH_LINES, default 1024, stored lines (power of two); LATENCY, default 4, BUSY cycles per read (>=1).
REQ-002 SHALL have ports: clk  in  1  clock; one clock; rst  in  1  reset, synchronous and active-high.
REQ-003 SHALL have port Dc_mem_req  in  1  line-read request, held high by the requester until MEM_mem_valid.
REQ-004 SHALL have port Dc_mem_addr  in  LINE_BITS  line index of the read.
REQ-005 SHALL have port MEM_data_line  out  128  returned line; word k at bits [32k+31:32k].
REQ-006 SHALL have port MEM_mem_valid  out  1  one-cycle pulse qualifying MEM_data_line.
REQ-007 SHALL have ports Dc_wb_we  in  1  write-back strobe; Dc_wb_addr  in  LINE_BITS  write-back line index; Dc_wb_wline  in  128  write-back line.
REQ-008 SHALL have ports rd_count  out  32  completed reads; wb_count  out  32  accepted write-backs.

Function
REQ-009 SHALL store DEPTH_LINES x 128-bit lines, indexed by the low log2(DEPTH_LINES) bits of a line index; upper bits ignored (aliasing).
REQ-010 SHALL implement FSM IDLE -> BUSY -> RESP -> IDLE.
REQ-011 IDLE: Dc_mem_req=1 at an edge SHALL latch Dc_mem_addr, load counter with LATENCY-1, enter BUSY; otherwise stay IDLE.
REQ-012 BUSY: Dc_mem_req=0 at an edge SHALL abort to IDLE with no MEM_mem_valid pulse and no rd_count change.
REQ-013 BUSY with request held and counter nonzero SHALL decrement the counter; Dc_mem_addr changes SHALL be ignored (latched index used).
REQ-014 BUSY with request held and counter zero SHALL register the latched line into MEM_data_line, set MEM_mem_valid, enter RESP.
REQ-015 Timing: request first sampled in IDLE at cycle T SHALL give MEM_mem_valid high exactly during cycle T+1+LATENCY.
REQ-016 RESP: MEM_mem_valid SHALL be high for exactly this one cycle; Dc_mem_req ignored; next state IDLE; MEM_mem_valid cleared.
REQ-017 MEM_data_line SHALL hold its last value until the next capture.
REQ-018 Dc_wb_we=1 at an edge SHALL write Dc_wb_wline to the Dc_wb_addr line in any FSM state, single cycle, no back-pressure.
REQ-019 Write and read capture (REQ-014) in the same cycle to the same stored line SHALL return the newly written data (write-first bypass).
REQ-020 rd_count SHALL increment on each MEM_mem_valid pulse; wb_count on each accepted write; both wrap modulo 2^32.
REQ-021 Dc_mem_req held high across RESP into IDLE SHALL start a new read at the first IDLE cycle (back-to-back, one idle cycle between pulses).

Reset
REQ-022 rst=1 at an edge SHALL force state IDLE, counter 0, MEM_mem_valid 0, MEM_data_line 0, rd_count 0, wb_count 0, including mid-BUSY or in RESP (in-flight read dropped, no pulse).
REQ-023 rst SHALL NOT clear stored line contents; a write-back in a reset cycle SHALL be ignored.

Verification
REQ-024 Write-back line 0x0005 = {0x44,0x33,0x22,0x11}; then Dc_mem_req=1, addr 0x0005 first sampled at T -> MEM_mem_valid high only in T+5 (LATENCY=4), MEM_data_line = {0x44,0x33,0x22,0x11}, rd_count=1.
REQ-025 Read 0x0007 pending; same cycle as capture, Dc_wb_we=1 to 0x0007 with 0xAAAA...AAAA -> returned line 0xAAAA...AAAA, wb_count incremented.
REQ-026 Dc_mem_req dropped in second BUSY cycle -> no MEM_mem_valid within 10 cycles, rd_count unchanged, next request completes normally.
REQ-027 Write 0x0403 (DEPTH_LINES=1024), read 0x0003 -> same data returned (alias).
REQ-028 rst asserted during BUSY -> next cycle state IDLE, all outputs 0; subsequent read of a previously written line returns pre-reset data.

Source files
------------

// File: rtl/dmem_line_responder_if.sv
// Line-read request/response and write-back signals between a data cache and its line memory.
// The master modport is the cache side and the slave modport is the memory side.
interface dmem_line_responder_if #(
    parameter int LINE_BITS = 16
);
    logic                 Dc_mem_req;
    logic [LINE_BITS-1:0] Dc_mem_addr;
    logic [127:0]         MEM_data_line;
    logic                 MEM_mem_valid;
    logic                 Dc_wb_we;
    logic [LINE_BITS-1:0] Dc_wb_addr;
    logic [127:0]         Dc_wb_wline;

    modport master (
        output Dc_mem_req, Dc_mem_addr, Dc_wb_we, Dc_wb_addr, Dc_wb_wline,
        input  MEM_data_line, MEM_mem_valid
    );

    modport slave (
        input  Dc_mem_req, Dc_mem_addr, Dc_wb_we, Dc_wb_addr, Dc_wb_wline,
        output MEM_data_line, MEM_mem_valid
    );
endinterface

// File: rtl/dmem_line_responder.sv
// Line memory that answers one read at a time after a fixed latency.
// Write-backs are accepted on any cycle and are visible to a read captured on the same edge.
module dmem_line_responder #(
    parameter int XLEN        = 32,
    parameter int LINE_BITS   = 16,
    parameter int DEPTH_LINES = 1024,
    parameter int LATENCY     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    dmem_line_responder_if.slave  bus,
    output logic [31:0]           rd_count,
    output logic [31:0]           wb_count
);
    localparam int LINE_W = 4 * XLEN;
    localparam int IDX_W  = (DEPTH_LINES > 1) ? $clog2(DEPTH_LINES) : 1;
    localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [IDX_W-1:0]   addr_q;
    logic [LINE_W-1:0]  line_q;
    logic               valid_q;
    logic [31:0]        rdCount_q;
    logic [31:0]        wbCount_q;

    logic [LINE_W-1:0]  mem [DEPTH_LINES];

    logic [IDX_W-1:0]   reqIdx;
    logic [IDX_W-1:0]   wbIdx;
    logic               wbAccept;
    logic [LINE_W-1:0]  lineCapture_d;
    logic               unusedAddrBits;

    // Only the low index bits select a line, so higher line indices alias.
    assign reqIdx         = bus.Dc_mem_addr[IDX_W-1:0];
    assign wbIdx          = bus.Dc_wb_addr[IDX_W-1:0];
    assign unusedAddrBits = ^{bus.Dc_mem_addr, bus.Dc_wb_addr};
    assign wbAccept       = bus.Dc_wb_we && !rst;

    assign lineCapture_d = (wbAccept && (wbIdx == addr_q)) ? bus.Dc_wb_wline : mem[addr_q];

    // Storage is deliberately left out of reset so contents survive it.
    always_ff @(posedge clk) begin
        if (wbAccept) begin
            mem[wbIdx] <= bus.Dc_wb_wline;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            line_q    <= '0;
            valid_q   <= 1'b0;
            rdCount_q <= '0;
            wbCount_q <= '0;
        end else begin
            valid_q <= 1'b0;
            if (bus.Dc_wb_we) begin
                wbCount_q <= wbCount_q + 32'd1;
            end
            case (state_q)
                IDLE: begin
                    if (bus.Dc_mem_req) begin
                        addr_q  <= reqIdx;
                        cnt_q   <= CNT_W'(LATENCY - 1);
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    // Dropping the request abandons the read without a response.
                    if (!bus.Dc_mem_req) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        line_q    <= lineCapture_d;
                        valid_q   <= 1'b1;
                        rdCount_q <= rdCount_q + 32'd1;
                        state_q   <= RESP;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.MEM_data_line = line_q;
    assign bus.MEM_mem_valid = valid_q;
    assign rd_count          = rdCount_q;
    assign wb_count          = wbCount_q;
endmodule

// File: tb/tb_dmem_line_responder.sv
// Directed bench for dmem_line_responder: reads, write-backs, bypass, abort, aliasing, reset.
// Expected responses go into a scoreboard queue that a negedge monitor drains.
module tb_dmem_line_responder;
    localparam int LAT = 4;

    localparam logic [127:0] L5    = 128'h00000044_00000033_00000022_00000011;
    localparam logic [127:0] L7OLD = 128'h12345678_9abcdef0_0fedcba9_87654321;
    localparam logic [127:0] LAAAA = 128'haaaaaaaa_aaaaaaaa_aaaaaaaa_aaaaaaaa;
    localparam logic [127:0] L403  = 128'hdeadbeef_cafef00d_01020304_a5a55a5a;
    localparam logic [127:0] L10   = 128'h10101010_20202020_30303030_40404040;
    localparam logic [127:0] L11   = 128'h11111111_22222222_33333333_44444444;
    localparam logic [127:0] L20   = 128'h0badf00d_00c0ffee_13579bdf_2468ace0;
    localparam logic [127:0] GARB  = 128'hffffffff_00000000_ffffffff_00000000;

    typedef struct {
        logic [127:0] line;
        int           cyc;
        int           rdCnt;
    } expT;

    logic        clk;
    logic        rst;
    logic [31:0] rd_count;
    logic [31:0] wb_count;

    int  cyc;
    int  total;
    int  bad;
    int  expRd;
    int  expWb;
    expT sbQ[$];
    expT monE;

    dmem_line_responder_if #(.LINE_BITS(16)) bus ();

    dmem_line_responder #(
        .XLEN        (32),
        .LINE_BITS   (16),
        .DEPTH_LINES (1024),
        .LATENCY     (LAT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .rd_count (rd_count),
        .wb_count (wb_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic writeLine(input logic [15:0] addr, input logic [127:0] line);
        bus.Dc_wb_we    = 1'b1;
        bus.Dc_wb_addr  = addr;
        bus.Dc_wb_wline = line;
        @(negedge clk);
        bus.Dc_wb_we = 1'b0;
        expWb++;
        checkOutput("wb_count", 128'(wb_count), 128'(expWb));
    endtask

    task automatic readLine(input logic [15:0] addr, input logic [127:0] line);
        bit seen;
        seen = 1'b0;
        bus.Dc_mem_req  = 1'b1;
        bus.Dc_mem_addr = addr;
        expRd++;
        sbQ.push_back('{line, cyc + 1 + LAT, expRd});
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.MEM_mem_valid === 1'b1) seen = 1'b1;
        end
        bus.Dc_mem_req = 1'b0;
        if (!seen) begin
            total++;
            bad++;
            $display("[TB] FAIL read_timeout: no valid for addr %0h within 20 cycles", addr);
        end
        @(negedge clk);
    endtask

    // Every valid pulse must match the oldest outstanding expectation, including its cycle.
    always @(negedge clk) begin
        if (bus.MEM_mem_valid === 1'b1) begin
            if (sbQ.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_valid: got valid=1 expected 0 (cycle %0d)", cyc);
            end else begin
                monE = sbQ.pop_front();
                checkOutput("resp_line", bus.MEM_data_line, monE.line);
                checkOutput("resp_cycle", 128'(cyc), 128'(monE.cyc));
                checkOutput("resp_rd_count", 128'(rd_count), 128'(monE.rdCnt));
            end
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int c;
        int vcount;
        total = 0;
        bad   = 0;
        expRd = 0;
        expWb = 0;
        rst             = 1'b1;
        bus.Dc_mem_req  = 1'b0;
        bus.Dc_mem_addr = '0;
        bus.Dc_wb_we    = 1'b0;
        bus.Dc_wb_addr  = '0;
        bus.Dc_wb_wline = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checkOutput("reset_valid", 128'(bus.MEM_mem_valid), 128'(0));
        checkOutput("reset_line", bus.MEM_data_line, 128'(0));
        checkOutput("reset_rd_count", 128'(rd_count), 128'(0));
        checkOutput("reset_wb_count", 128'(wb_count), 128'(0));

        // Basic write-back then read with latency check.
        writeLine(16'h0005, L5);
        readLine(16'h0005, L5);
        checkOutput("hold_valid", 128'(bus.MEM_mem_valid), 128'(0));
        checkOutput("hold_line", bus.MEM_data_line, L5);

        // Write-back landing on the capture edge must be bypassed into the response.
        writeLine(16'h0007, L7OLD);
        c = cyc;
        bus.Dc_mem_req  = 1'b1;
        bus.Dc_mem_addr = 16'h0007;
        expRd++;
        sbQ.push_back('{LAAAA, c + 1 + LAT, expRd});
        repeat (LAT) @(negedge clk);
        bus.Dc_wb_we    = 1'b1;
        bus.Dc_wb_addr  = 16'h0007;
        bus.Dc_wb_wline = LAAAA;
        @(negedge clk);
        bus.Dc_wb_we   = 1'b0;
        bus.Dc_mem_req = 1'b0;
        expWb++;
        checkOutput("bypass_wb_count", 128'(wb_count), 128'(expWb));
        @(negedge clk);
        readLine(16'h0007, LAAAA);

        // Request withdrawn in the second busy cycle: no response, no count.
        bus.Dc_mem_req  = 1'b1;
        bus.Dc_mem_addr = 16'h0005;
        repeat (2) @(negedge clk);
        bus.Dc_mem_req = 1'b0;
        vcount = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.MEM_mem_valid === 1'b1) vcount++;
        end
        checkOutput("abort_valids", 128'(vcount), 128'(0));
        checkOutput("abort_rd_count", 128'(rd_count), 128'(expRd));
        readLine(16'h0005, L5);

        // Upper index bits alias onto the same stored line.
        writeLine(16'h0403, L403);
        readLine(16'h0003, L403);

        // Held request: address change while busy is ignored, then an immediate second read.
        writeLine(16'h0010, L10);
        writeLine(16'h0011, L11);
        c = cyc;
        bus.Dc_mem_req  = 1'b1;
        bus.Dc_mem_addr = 16'h0010;
        expRd++;
        sbQ.push_back('{L10, c + 1 + LAT, expRd});
        expRd++;
        sbQ.push_back('{L11, c + 3 + 2 * LAT, expRd});
        repeat (2) @(negedge clk);
        bus.Dc_mem_addr = 16'h0011;
        repeat (9) @(negedge clk);
        bus.Dc_mem_req = 1'b0;
        @(negedge clk);

        // Reset mid-read drops it and clears outputs but keeps stored lines; a reset-cycle write is lost.
        writeLine(16'h0020, L20);
        bus.Dc_mem_req  = 1'b1;
        bus.Dc_mem_addr = 16'h0020;
        repeat (2) @(negedge clk);
        rst             = 1'b1;
        bus.Dc_mem_req  = 1'b0;
        bus.Dc_wb_we    = 1'b1;
        bus.Dc_wb_addr  = 16'h0020;
        bus.Dc_wb_wline = GARB;
        @(negedge clk);
        rst          = 1'b0;
        bus.Dc_wb_we = 1'b0;
        expRd = 0;
        expWb = 0;
        checkOutput("midreset_valid", 128'(bus.MEM_mem_valid), 128'(0));
        checkOutput("midreset_line", bus.MEM_data_line, 128'(0));
        checkOutput("midreset_rd_count", 128'(rd_count), 128'(0));
        checkOutput("midreset_wb_count", 128'(wb_count), 128'(0));
        readLine(16'h0020, L20);
        checkOutput("postreset_wb_count", 128'(wb_count), 128'(0));

        for (int i = 0; i < 20 && sbQ.size() != 0; i++) @(negedge clk);
        checkOutput("scoreboard_drained", 128'(sbQ.size()), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
